// File: rtl/adiabatic_pkg.sv
// rtl/adiabatic_pkg.sv - shared phase and sequencer state encodings
package adiabatic_pkg;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    HOLD = 2'd1,
    DOWN = 2'd2,
    IDLE = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/adiabatic_phase_ctr.sv
// rtl/adiabatic_phase_ctr.sv - tick/quarter counter with clear and boundary strobe
module adiabatic_phase_ctr #(
  parameter int PHASE_CYC = 4,
  parameter int TW        = $clog2(PHASE_CYC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic [TW-1:0] tick_o,
  output logic [1:0]    q_o,
  output logic          boundary_o
);

  localparam logic [TW-1:0] LAST = TW'(PHASE_CYC - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    q_q, q_d;

  assign boundary_o = (tick_q == LAST);
  assign tick_o     = tick_q;
  assign q_o        = q_q;

  always_comb begin
    tick_d = tick_q;
    q_d    = q_q;
    if (clr_i) begin
      tick_d = '0;
      q_d    = '0;
    end else if (boundary_o) begin
      tick_d = '0;
      q_d    = q_q + 2'd1;
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= '0;
      q_q    <= '0;
    end else begin
      tick_q <= tick_d;
      q_q    <= q_d;
    end
  end

endmodule

// File: rtl/adiabatic_pclk_seq.sv
// rtl/adiabatic_pclk_seq.sv - four-phase power-clock sequencer with wake/park waves and token tracking
module adiabatic_pclk_seq
  import adiabatic_pkg::*;
#(
  parameter int NSTAGES   = 4,
  parameter int PHASE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   busy,
  output logic [2*NSTAGES-1:0]   phase,
  output logic [NSTAGES-1:0]     ramp_up,
  output logic [NSTAGES-1:0]     ramp_dn
);

  localparam int TW = $clog2(PHASE_CYC);

  seq_state_e         state_q, state_d;
  logic [NSTAGES-1:0] act_q, act_d;
  logic [NSTAGES:0]   tok_q, tok_d;
  logic [NSTAGES-1:0] wake, park;
  logic [TW-1:0]      tick;
  logic [1:0]         q;
  logic               bnd;
  logic               ctr_clr;
  logic               launch;

  assign ctr_clr = (state_q == OFF) || (state_d == OFF);

  adiabatic_phase_ctr #(
    .PHASE_CYC (PHASE_CYC),
    .TW        (TW)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (ctr_clr),
    .tick_o     (tick),
    .q_o        (q),
    .boundary_o (bnd)
  );

  assign in_ready  = (state_q == RUN) && (q == 2'd3) && bnd;
  assign launch    = in_valid && in_ready;
  assign busy      = (state_q != OFF);
  // tok_q[NSTAGES] marks the last stage in HOLD; tick==0 is its first cycle there
  assign out_valid = tok_q[NSTAGES] && (tick == '0);

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam logic [1:0] KOFF = 2'(k % 4);
    logic [1:0] nom, nom_next;

    assign nom      = q - KOFF;
    assign nom_next = q + 2'd1 - KOFF;

    assign phase[2*k +: 2] = act_q[k] ? nom : 2'(IDLE);
    assign ramp_up[k]      = act_q[k] && (nom == 2'(UP));
    assign ramp_dn[k]      = act_q[k] && (nom == 2'(DOWN));

    if (k == 0) begin : g_first
      assign wake[k] = 1'b0;
      assign park[k] = (state_q == DRAIN) && bnd && act_q[k] && (nom_next == 2'(IDLE));
    end else begin : g_rest
      // each wave advances only behind its neighbour, so parking always trails tokens
      assign wake[k] = (state_q != OFF) && bnd && !act_q[k] && act_q[k-1]
                       && (nom_next == 2'(UP));
      assign park[k] = (state_q == DRAIN) && bnd && act_q[k] && !act_q[k-1]
                       && (nom_next == 2'(IDLE));
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = (act_q | wake) & ~park;
    tok_d   = tok_q;
    if (bnd && (state_q != OFF)) begin
      tok_d = {tok_q[NSTAGES-1:0], launch};
    end
    case (state_q)
      OFF: begin
        if (en) begin
          state_d = RUN;
          act_d   = NSTAGES'(1);
        end
      end
      RUN: begin
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (act_d == '0) begin
          state_d = OFF;
          tok_d   = '0;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OFF;
      act_q   <= '0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      tok_q   <= tok_d;
    end
  end

endmodule

// File: tb/tb_adiabatic_pclk_seq.sv
// tb/tb_adiabatic_pclk_seq.sv - directed and sweep bench for adiabatic_pclk_seq
module tb_adiabatic_pclk_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, in_valid;
  logic        in_ready, out_valid, busy;
  logic [7:0]  phase;
  logic [3:0]  ramp_up, ramp_dn;

  logic        en_b, iv_b;
  logic        ir_b, ov_b, busy_b;
  logic [11:0] phase_b;
  logic [5:0]  ru_b, rd_b;

  int errors = 0;
  int checks = 0;

  int hs_cyc[$];
  int ov_cyc[$];
  int first_up[4];
  int last_dn[4];
  int bad_pre;
  int ir_late;
  int busy_off;

  always #5 clk = ~clk;

  adiabatic_pclk_seq #(.NSTAGES(4), .PHASE_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .phase     (phase),
    .ramp_up   (ramp_up),
    .ramp_dn   (ramp_dn)
  );

  adiabatic_pclk_seq #(.NSTAGES(6), .PHASE_CYC(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_b),
    .in_valid  (iv_b),
    .in_ready  (ir_b),
    .out_valid (ov_b),
    .busy      (busy_b),
    .phase     (phase_b),
    .ramp_up   (ru_b),
    .ramp_dn   (rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".phase"},     32'(phase),     32'hFF);
    chk({tag, ".ramp_up"},   32'(ramp_up),   32'd0);
    chk({tag, ".ramp_dn"},   32'(ramp_dn),   32'd0);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; en_b = 1'b0; iv_b = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // cycle 0 is the current cycle; cycle c is the period after the c-th following edge
  task automatic run(input int ncyc, input int max_launch, input int drop_en_at);
    bit drop_next = 1'b0;
    hs_cyc.delete();
    ov_cyc.delete();
    bad_pre = 0; ir_late = 0; busy_off = -1;
    for (int k = 0; k < 4; k++) begin
      first_up[k] = -1;
      last_dn[k]  = -1;
    end
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (drop_next) in_valid = 1'b0;
      if (c == drop_en_at) en = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (first_up[k] < 0 && phase[2*k +: 2] inside {2'd1, 2'd2}) bad_pre++;
        if (ramp_up[k] && first_up[k] < 0) first_up[k] = c;
        if (ramp_dn[k]) last_dn[k] = c;
      end
      if (out_valid) ov_cyc.push_back(c);
      if (drop_en_at > 0 && c >= drop_en_at && in_ready) ir_late++;
      if (!busy && busy_off < 0) busy_off = c;
      if (in_ready && in_valid) begin
        hs_cyc.push_back(c);
        if (hs_cyc.size() >= max_launch) drop_next = 1'b1;
      end
    end
  endtask

  initial begin
    int launches, ovs, overlap, illegal, budget;
    logic [1:0] prev_ph[6];
    logic [1:0] cur;

    // reset state
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; en_b = 1'b0; iv_b = 1'b0;
    step();
    chk_reset("reset");
    step();
    rst_n = 1'b1;

    // start-up wave and single launch
    en = 1'b1; in_valid = 1'b1;
    run(45, 1, 0);
    chk("start.busy_off_never", 32'(busy_off), -32'sd1);
    for (int k = 0; k < 4; k++) chk($sformatf("start.first_up%0d", k), 32'(first_up[k]), 32'(1 + 4*k));
    chk("start.no_early_hold_down", 32'(bad_pre), 32'd0);
    chk("single.hs_count", 32'(hs_cyc.size()), 32'd1);
    if (hs_cyc.size() >= 1) chk("single.hs_cycle", 32'(hs_cyc[0]), 32'd16);
    chk("single.ov_count", 32'(ov_cyc.size()), 32'd1);
    if (ov_cyc.size() >= 1) chk("single.ov_cycle", 32'(ov_cyc[0]), 32'd33);

    // back-to-back launches
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    run(80, 3, 0);
    chk("b2b.hs_count", 32'(hs_cyc.size()), 32'd3);
    chk("b2b.ov_count", 32'(ov_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (hs_cyc.size() > i) chk($sformatf("b2b.hs%0d", i), 32'(hs_cyc[i]), 32'(16 + 16*i));
      if (ov_cyc.size() > i) chk($sformatf("b2b.ov%0d", i), 32'(ov_cyc[i]), 32'(33 + 16*i));
    end

    // drain with a token in flight
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    run(50, 1, 18);
    chk("drain.ov_count", 32'(ov_cyc.size()), 32'd1);
    if (ov_cyc.size() >= 1) chk("drain.ov_cycle", 32'(ov_cyc[0]), 32'd33);
    for (int k = 0; k < 4; k++) chk($sformatf("drain.last_dn%0d", k), 32'(last_dn[k]), 32'(28 + 4*k));
    chk("drain.busy_off", 32'(busy_off), 32'd41);
    chk("drain.in_ready_late", 32'(ir_late), 32'd0);
    chk("drain.phase_idle", 32'(phase), 32'hFF);

    // reset mid-run with a token present
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    run(20, 1, 0);
    chk("midrst.hs_cycle", 32'(hs_cyc.size() >= 1 ? hs_cyc[0] : -1), 32'd16);
    rst_n = 1'b0;
    step();
    chk_reset("midrst");
    rst_n = 1'b1; en = 1'b0; in_valid = 1'b0;
    run(40, 1, 0);
    chk("midrst.no_ov", 32'(ov_cyc.size()), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);

    // random sweep at NSTAGES=6, PHASE_CYC=3
    do_reset();
    launches = 0; ovs = 0; overlap = 0; illegal = 0;
    for (int k = 0; k < 6; k++) prev_ph[k] = phase_b[2*k +: 2];
    for (int c = 0; c < 10000; c++) begin
      step();
      if (ov_b) ovs++;
      if ((ru_b & rd_b) != 6'd0) overlap++;
      for (int k = 0; k < 6; k++) begin
        cur = phase_b[2*k +: 2];
        if (cur != prev_ph[k] && cur != prev_ph[k] + 2'd1) illegal++;
        prev_ph[k] = cur;
      end
      en_b = ($urandom_range(0, 31) != 0);
      iv_b = $urandom_range(0, 1) == 1;
      if (ir_b && iv_b) launches++;
    end
    en_b = 1'b0; iv_b = 1'b0;
    budget = 0;
    while (busy_b && budget < 300) begin
      step();
      budget++;
      if (ov_b) ovs++;
      if ((ru_b & rd_b) != 6'd0) overlap++;
      for (int k = 0; k < 6; k++) begin
        cur = phase_b[2*k +: 2];
        if (cur != prev_ph[k] && cur != prev_ph[k] + 2'd1) illegal++;
        prev_ph[k] = cur;
      end
    end
    chk("sweep.drained", 32'(busy_b), 32'd0);
    chk("sweep.ramp_overlap", 32'(overlap), 32'd0);
    chk("sweep.illegal_phase_step", 32'(illegal), 32'd0);
    chk("sweep.some_launches", 32'(launches > 0), 32'd1);
    chk("sweep.ov_eq_launch", 32'(ovs), 32'(launches));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
